paralelo_serial_tx: RTL and testbench

Transmit-side serializer that feeds the PHY receive deserializer across the serial link. It accepts bytes from the TX logic through a valid/ready handshake and shifts them out MSB-first, one bit per `clk_32f` cycle. After every reset it first sends a fixed burst of comma bytes (0xBC) so the receiver can reach its active state. It sends comma bytes as idle fill whenever no data byte is offered.

---
 rtl/paralelo_serial_tx.sv | 96 +++++++++
 tb/tb_paralelo_serial_tx.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/paralelo_serial_tx.sv
// Byte-to-serial transmitter: sends a comma burst after reset, then shifts out
// handshaked data bytes MSB-first, using comma bytes as idle fill.
module paralelo_serial_tx #(
    parameter logic [7:0]  COMMA      = 8'hBC,
    parameter int unsigned SYNC_BYTES = 4
) (
    input  logic       clk_32f,
    input  logic       rst,
    input  logic [7:0] data_in,
    input  logic       valid_in,
    output logic       ready_out,
    output logic       data_out,
    output logic       active_out
);

    localparam int unsigned CNT_W  = 3;
    localparam int unsigned BYTE_W = 8;
    localparam int unsigned SYNC_W = 4;

    typedef enum logic {
        SYNC   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [BYTE_W-1:0]   tx_byte_q, tx_byte_d;
    logic [SYNC_W-1:0]   sync_cnt_q, sync_cnt_d;
    logic                data_q, data_d;
    logic                active_q, active_d;

    logic                boundary;
    logic                last_sync;
    logic [BYTE_W-1:0]   next_byte;

    assign boundary  = (cnt_q == CNT_W'(BYTE_W - 1));
    assign last_sync = (sync_cnt_q == SYNC_W'(SYNC_BYTES - 1));
    assign next_byte = valid_in ? data_in : COMMA;

    // Ready is the load window: only at a byte boundary once data may follow.
    assign ready_out = !rst && boundary && ((state_q == ACTIVE) || last_sync);

    // State register with synchronous reset.
    always_ff @(posedge clk_32f) begin
        if (rst) begin
            state_q    <= SYNC;
            cnt_q      <= '0;
            tx_byte_q  <= COMMA;
            sync_cnt_q <= '0;
            data_q     <= 1'b0;
            active_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            tx_byte_q  <= tx_byte_d;
            sync_cnt_q <= sync_cnt_d;
            data_q     <= data_d;
            active_q   <= active_d;
        end
    end

    // Next-state: shift one bit per cycle and choose the next byte at a boundary.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q + CNT_W'(1);
        tx_byte_d  = tx_byte_q;
        sync_cnt_d = sync_cnt_q;
        data_d     = tx_byte_q[~cnt_q];
        active_d   = active_q;

        if (boundary) begin
            unique case (state_q)
                SYNC: begin
                    if (last_sync) begin
                        state_d   = ACTIVE;
                        active_d  = 1'b1;
                        tx_byte_d = next_byte;
                    end else begin
                        sync_cnt_d = sync_cnt_q + SYNC_W'(1);
                        tx_byte_d  = COMMA;
                    end
                end
                ACTIVE: begin
                    tx_byte_d = next_byte;
                end
                default: begin
                    state_d = SYNC;
                end
            endcase
        end
    end

    assign data_out   = data_q;
    assign active_out = active_q;

endmodule

// File: tb/tb_paralelo_serial_tx.sv
// Directed bench for paralelo_serial_tx: sync burst, byte stream table, reset mid-byte.
module tb_paralelo_serial_tx;

    logic       clk_32f = 1'b0;
    logic       rst;
    logic [7:0] data_in;
    logic       valid_in;
    logic       ready_out;
    logic       data_out;
    logic       active_out;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] comma = 8'hBC;

    typedef struct {
        logic       valid;
        logic [7:0] data;
        logic [7:0] exp_byte;
    } vec_t;

    vec_t vecs[12];

    paralelo_serial_tx #(
        .COMMA      (8'hBC),
        .SYNC_BYTES (4)
    ) dut (
        .clk_32f    (clk_32f),
        .rst        (rst),
        .data_in    (data_in),
        .valid_in   (valid_in),
        .ready_out  (ready_out),
        .data_out   (data_out),
        .active_out (active_out)
    );

    always #5 clk_32f = ~clk_32f;

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    task automatic step();
        @(posedge clk_32f);
        #1;
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic check_reset_state(input string tag);
        check1({tag, " data_out"},   data_out,   1'b0);
        check1({tag, " ready_out"},  ready_out,  1'b0);
        check1({tag, " active_out"}, active_out, 1'b0);
    endtask

    // Edges 1..31 after reset release: commas, inactive, ready only after edge 31.
    task automatic check_burst(input string tag);
        for (int n = 1; n <= 31; n++) begin
            step();
            check1($sformatf("%s bit e%0d", tag, n), data_out, comma[7 - ((n - 1) % 8)]);
            check1($sformatf("%s ready e%0d", tag, n), ready_out, logic'(n == 31));
            check1($sformatf("%s active e%0d", tag, n), active_out, 1'b0);
        end
    endtask

    initial begin
        logic [7:0] prev;
        logic [7:0] f0;

        vecs[0]  = '{1'b1, 8'hA5, 8'hA5};
        vecs[1]  = '{1'b1, 8'hA5, 8'hA5};
        vecs[2]  = '{1'b1, 8'h01, 8'h01};
        vecs[3]  = '{1'b1, 8'hFF, 8'hFF};
        vecs[4]  = '{1'b1, 8'h3C, 8'h3C};
        vecs[5]  = '{1'b1, 8'h55, 8'h55};
        vecs[6]  = '{1'b0, 8'h77, 8'hBC};
        vecs[7]  = '{1'b1, 8'hAA, 8'hAA};
        vecs[8]  = '{1'b0, 8'h00, 8'hBC};
        vecs[9]  = '{1'b1, 8'hBC, 8'hBC};
        vecs[10] = '{1'b1, 8'h80, 8'h80};
        vecs[11] = '{1'b0, 8'h5A, 8'hBC};

        rst      = 1'b1;
        valid_in = 1'b0;
        data_in  = 8'h00;

        // Reset held: all outputs low every cycle.
        for (int i = 0; i < 3; i++) begin
            step();
            check_reset_state($sformatf("rst_hold%0d", i));
        end

        // Idle stream for 64 edges with valid low.
        rst = 1'b0;
        for (int n = 1; n <= 64; n++) begin
            step();
            check1($sformatf("idle bit e%0d", n), data_out, comma[7 - ((n - 1) % 8)]);
            check1($sformatf("idle ready e%0d", n), ready_out, logic'((n % 8 == 7) && (n >= 31)));
            check1($sformatf("idle active e%0d", n), active_out, logic'(n >= 32));
        end

        // Re-reset with A5 offered throughout the burst: must not be taken early.
        rst = 1'b1;
        step();
        check_reset_state("rst2");
        rst      = 1'b0;
        valid_in = 1'b1;
        data_in  = 8'hA5;
        check_burst("a5burst");

        // Table: positioned in the ready cycle before each boundary edge.
        prev = comma;
        foreach (vecs[i]) begin
            valid_in = vecs[i].valid;
            data_in  = vecs[i].data;
            check1($sformatf("vec%0d ready", i), ready_out, 1'b1);
            step();
            check1($sformatf("vec%0d prev lsb", i), data_out, prev[0]);
            check1($sformatf("vec%0d active", i), active_out, 1'b1);
            // Inputs between boundaries must be ignored.
            valid_in = ~vecs[i].valid;
            data_in  = 8'(~vecs[i].data);
            for (int j = 0; j < 7; j++) begin
                step();
                check1($sformatf("vec%0d bit%0d", i, 7 - j), data_out, vecs[i].exp_byte[7 - j]);
                check1($sformatf("vec%0d ready b%0d", i, j), ready_out, logic'(j == 6));
            end
            prev = vecs[i].exp_byte;
        end

        // Reset at cnt==3 while sending F0, with F0 still pending afterwards.
        f0       = 8'hF0;
        valid_in = 1'b1;
        data_in  = f0;
        check1("f0 ready", ready_out, 1'b1);
        step();
        check1("f0 prev lsb", data_out, prev[0]);
        for (int j = 0; j < 3; j++) begin
            step();
            check1($sformatf("f0 pre bit%0d", 7 - j), data_out, f0[7 - j]);
        end
        rst = 1'b1;
        check1("f0 rst ready comb", ready_out, 1'b0);
        step();
        check_reset_state("midrst0");
        step();
        check_reset_state("midrst1");
        rst = 1'b0;
        check_burst("postrst");
        step();
        check1("postrst e32 bit", data_out, comma[0]);
        check1("postrst e32 active", active_out, 1'b1);
        for (int j = 0; j < 8; j++) begin
            step();
            check1($sformatf("postrst f0 bit%0d", 7 - j), data_out, f0[7 - j]);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
